// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the set-associative D-cache.
// Hit path zero-cycle; metadata tag field is sized for the widest tag any geometry needs.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  // Tags are zero-extended into this field so one struct fits every geometry.
  localparam int META_TAG_W = 32;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [META_TAG_W-1:0] tag;
  } meta_t;

  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int addr_w, input int sets);
    return addr_w - 2 - $clog2(sets);
  endfunction

  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set true-LRU age tracker; victim is the way whose age is WAYS-1.
// Victim readout is combinational from state; ages update at the posedge when upd_en is set.
module dcache_lru
  import dcache_pkg::*;
#(
  parameter int SETS = 64,
  parameter int WAYS = 2,
  localparam int IDX_W = idx_width(SETS),
  localparam int WAY_W = way_width(WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [WAY_W-1:0] upd_way,
  output logic [WAY_W-1:0] victim
);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] old_age;

  assign old_age = age_q[idx][upd_way];

  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
  end

  // Ages stay a permutation: only ways younger than the accessed one move up.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (upd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way) begin
          age_q[idx][w] <= '0;
        end else if (age_q[idx][w] < old_age) begin
          age_q[idx][w] <= age_q[idx][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dcache_set_assoc.sv
// N-way write-back/write-allocate D-cache; hits zero-cycle, misses cost 1+L (clean) or 1+2L (dirty).
// Stalls the pipeline through every miss; memory request held until mem_ack. Perf counters via DCACHE_PERF_CNT_EN.
module dcache_set_assoc
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses,
  output logic [31:0]       perf_writebacks
`endif
);

  localparam int IDX_W = idx_width(SETS);
  localparam int TAG_W = tag_width(ADDR_W, SETS);
  localparam int WAY_W = way_width(WAYS);

  state_t state_q, state_d;
  meta_t             meta_q [SETS][WAYS];
  logic [DATA_W-1:0] data_q [SETS][WAYS];

  logic [IDX_W-1:0] idx, idx_q;
  logic [TAG_W-1:0] tag, tag_q;
  logic [WAY_W-1:0] hit_way, inv_way, lru_victim, victim, vway_q;
  logic             hit, inv_found, victim_dirty, idle_hit, idle_miss;
  logic             unused_addr_bits;

  assign idx = cpu_addr[2 +: IDX_W];
  assign tag = cpu_addr[ADDR_W-1 -: TAG_W];
  // Byte offset is irrelevant for word lines.
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (meta_q[idx][w].valid && (meta_q[idx][w].tag == META_TAG_W'(tag))) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!meta_q[idx][w].valid) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim       = inv_found ? inv_way : lru_victim;
  assign victim_dirty = meta_q[idx][victim].valid && meta_q[idx][victim].dirty;
  assign idle_hit     = (state_q == IDLE) && cpu_req && hit;
  assign idle_miss    = (state_q == IDLE) && cpu_req && !hit;

  assign cpu_hit   = (state_q == IDLE) && hit;
  assign cpu_stall = (state_q != IDLE) || (cpu_req && !hit);
  assign cpu_rdata = idle_hit ? data_q[idx][hit_way] : '0;

  dcache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk     (clk),
    .reset   (reset),
    .upd_en  (idle_hit),
    .idx     (idx),
    .upd_way (hit_way),
    .victim  (lru_victim)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (idle_miss) state_d = victim_dirty ? WRITEBACK : REFILL;
      WRITEBACK: if (mem_ack)   state_d = REFILL;
      REFILL:    if (mem_ack)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Memory-side outputs are registered so they stay stable until mem_ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
      vway_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_miss) begin
            idx_q     <= idx;
            tag_q     <= tag;
            vway_q    <= victim;
            mem_req   <= 1'b1;
            mem_we    <= victim_dirty;
            mem_addr  <= victim_dirty ? {meta_q[idx][victim].tag[TAG_W-1:0], idx, 2'b00}
                                      : {tag, idx, 2'b00};
            mem_wdata <= data_q[idx][victim];
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            mem_we   <= 1'b0;
            mem_addr <= {tag_q, idx_q, 2'b00};
          end
        end
        REFILL: begin
          if (mem_ack) mem_req <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          meta_q[s][w] <= '0;
        end
      end
    end else begin
      if (idle_hit && cpu_we) meta_q[idx][hit_way].dirty <= 1'b1;
      if ((state_q == WRITEBACK) && mem_ack) meta_q[idx_q][vway_q].dirty <= 1'b0;
      if ((state_q == REFILL) && mem_ack) begin
        meta_q[idx_q][vway_q] <= '{valid: 1'b1, dirty: 1'b0, tag: META_TAG_W'(tag_q)};
      end
    end
  end

  // Line data needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (idle_hit && cpu_we) data_q[idx][hit_way] <= cpu_wdata;
    if ((state_q == REFILL) && mem_ack) data_q[idx_q][vway_q] <= mem_rdata;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic replay_q;

  // The first IDLE cycle after a refill is the replay of the missed access, not a new hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      replay_q        <= 1'b0;
      perf_hits       <= '0;
      perf_misses     <= '0;
      perf_writebacks <= '0;
    end else begin
      replay_q <= (state_q == REFILL) && mem_ack;
      if (idle_hit && !replay_q && (perf_hits != '1)) perf_hits <= perf_hits + 32'd1;
      if (idle_miss && (perf_misses != '1)) perf_misses <= perf_misses + 32'd1;
      if ((state_q == WRITEBACK) && mem_ack && (perf_writebacks != '1)) begin
        perf_writebacks <= perf_writebacks + 32'd1;
      end
    end
  end
`endif

endmodule
